dec_pack_fifo: RTL and testbench
================================

Name: dec_pack_fifo

Overview:
- Downstream stage of the decimating FIR. Consumes its 8-bit decimated samples, one per vd_i strobe.
- Packs four samples into one 32-bit word, little-endian, and buffers the words in a synchronous FIFO.
- Presents the words on a valid/ready interface to the capture/transport logic.
- Runs entirely in the clk_data domain, the same domain that produces vd_i and data_i.

Parameters:
- DEPTH, 16: FIFO depth in 32-bit words; must be a power of 2, minimum 2.
- AW, 4: FIFO address width; must equal log2(DEPTH).
- BYTES_W, 4: samples per packed word. The value is fixed at 4; any other value is illegal.

Ports:
- clk_data  in  1: single clock. All state updates on its posedge.
- rst_n  in  1: asynchronous, active-low reset.
- vd_i  in  1: sample strobe from the FIR. Each clk_data cycle with vd_i=1 carries exactly one sample.
- data_i  in  8: signed decimated sample, accepted when vd_i=1.
- clear_i  in  1: synchronous clear of the packer, FIFO and ovf_o.
- flush_i  in  1: pushes a partial word. Active only with DEC_PACK_FLUSH_EN; ignored otherwise.
- data_o  out  32: head word of the FIFO.
- valid_o  out  1: data_o holds a valid word.
- ready_i  in  1: consumer accepts the word when valid_o=1 and ready_i=1.
- level_o  out  AW+1: number of words currently stored, range 0..DEPTH.
- ovf_o  out  1: sticky overflow flag.

Behaviour:
- Reset (rst_n=0, asynchronous) clears all state, which forces these output values:
  - data_o=0, valid_o=0, level_o=0, ovf_o=0.
  - byte_cnt=0, pack register=0, read and write pointers=0.
- Packer:
  - byte_cnt is a 2-bit counter. On each vd_i=1, data_i is stored in byte lane byte_cnt: lane 0 = bits 7:0, lane 3 = bits 31:24.
  - When byte_cnt==3 and vd_i=1, the word {data_i, lane2, lane1, lane0} is pushed at that same edge, and byte_cnt wraps to 0.
- Push and pop:
  - A pop occurs when valid_o && ready_i.
  - A push is accepted if level<DEPTH, or if a pop occurs in the same cycle. When full, a simultaneous push and pop are both performed and level is unchanged.
  - If the FIFO is full with no pop, the pushed word is dropped, ovf_o is set to 1 and held until clear_i or reset, and the FIFO contents are unchanged.
- FIFO output and latency:
  - Show-ahead: data_o is registered from the head entry. valid_o = (level>0), registered.
  - A word pushed into an empty FIFO at edge k appears with valid_o=1 after edge k+1. The latency from the 4th sample strobe to valid_o is therefore 2 edges.
  - After a pop at edge k, the next word (if any) is on data_o after edge k with no bubble.
  - level_o is updated at the same edge as each push and pop.
  - data_o holds its last value while valid_o=0.
  - valid_o never drops while ready_i=0.
  - data_o is stable while valid_o=1 and ready_i=0.
- clear_i: at the next edge, byte_cnt=0, pack register=0, pointers=0, level_o=0, valid_o=0 and ovf_o=0. clear_i has priority over vd_i, flush_i and ready_i in the same cycle.
- Reset mid-word: any partial word is discarded with no push. Reset mid-handshake: valid_o drops immediately, asynchronously.
- Arithmetic: samples are packed as raw bits, with no sign extension and no saturation. Pointers are AW bits and wrap modulo DEPTH. level is AW+1 bits.

Optional Feature:
- Macro: DEC_PACK_FLUSH_EN.
- Defined: flush_i=1 with byte_cnt>0 pushes the partial word. Unfilled upper lanes are 0x00, and the pushed word follows the same full/overflow rules as a normal push. byte_cnt then returns to 0.
  - If vd_i=1 in the same cycle, the current sample is first placed in its lane and then the word is flushed.
  - flush_i with byte_cnt==0 and vd_i=0 has no effect.
- Not defined: flush_i is unconnected internally. Behaviour is identical to flush_i=0.

Decomposition:
- Package dec_pack_pkg:
  - SAMPLE_W=8, WORD_W=32, LANES=4.
  - Typedef sample_t [7:0] and word_t [31:0].
  - Function lane_insert(word, lane, sample).
- Sub-module dec_pack_fifo_mem: DEPTH x 32 register array with write enable, write address, read address and read data. Pointers, level and the flags stay in the top level.

Test Plan:
- Four strobes with data_i=0x11,0x22,0x33,0x44, ready_i=1 -> valid_o rises 2 edges after the 4th strobe, data_o=0x44332211, level_o goes 1->0 on the pop.
- ready_i=0, 17 words pushed (68 strobes, DEPTH=16) -> level_o=16, 17th word dropped, ovf_o=1 and held; with ready_i=1 the first 16 words drain in order.
- Full FIFO with ready_i=1 and a push in the same cycle -> level_o stays 16, ovf_o stays 0, and the new word is the last one read.
- 6 strobes, then clear_i=1 -> level_o=0, valid_o=0, ovf_o=0. The next 4 strobes 0xA0..0xA3 yield 0xA3A2A1A0.
- rst_n low for half a cycle mid-word with valid_o=1 -> valid_o and level_o are 0 immediately, and no stale lanes appear in the next word.
- DEC_PACK_FLUSH_EN defined: 2 strobes 0x7F,0x80, then flush_i -> data_o=0x0000807F. Without the macro, the same stimulus gives no word and byte_cnt stays at 2.

Source files
------------

// File: rtl/dec_pack_pkg.sv
// dec_pack_pkg: shared widths, sample/word types and the byte-lane insert helper
package dec_pack_pkg;
  localparam int SAMPLE_W = 8;
  localparam int WORD_W = 32;
  localparam int LANES = 4;
  typedef logic [SAMPLE_W-1:0] sample_t;
  typedef logic [WORD_W-1:0] word_t;
  function automatic word_t lane_insert(word_t w, logic [1:0] lane, sample_t s);
    word_t r = w;
    r[lane*SAMPLE_W +: SAMPLE_W] = s;
    return r;
  endfunction
endpackage

// File: rtl/dec_pack_fifo_if.sv
// dec_pack_fifo_if: packed-word valid/ready stream
//   data  : head word, valid : data holds a word, ready : consumer accepts
//   master drives data/valid, slave drives ready
interface dec_pack_fifo_if;
  import dec_pack_pkg::*;
  word_t data;
  logic valid;
  logic ready;
  modport master(output data, output valid, input ready);
  modport slave(input data, input valid, output ready);
endinterface

// File: rtl/dec_pack_fifo_mem.sv
// dec_pack_fifo_mem: DEPTH x 32 register array, registered write, combinational read
//   clk_data : clock, we/wa/wd : write port, ra/rd : read port
module dec_pack_fifo_mem
  import dec_pack_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW = 4
) (
  input  logic          clk_data,
  input  logic          we,
  input  logic [AW-1:0] wa,
  input  word_t         wd,
  input  logic [AW-1:0] ra,
  output word_t         rd
);
  word_t mem [DEPTH];
  always_ff @(posedge clk_data)
    if (we) mem[wa] <= wd;
  assign rd = mem[ra];
endmodule

// File: rtl/dec_pack_fifo.sv
// dec_pack_fifo: packs four 8-bit samples little-endian into 32-bit words and buffers them in a show-ahead FIFO
//   clk_data, rst_n (async, active-low) : clock and reset
//   vd_i/data_i : sample strobe and sample, clear_i : sync clear of packer, FIFO and ovf_o
//   flush_i : push partial word, only when DEC_PACK_FLUSH_EN is defined
//   dout : word stream (master), level_o : stored words, ovf_o : sticky overflow
module dec_pack_fifo
  import dec_pack_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW = 4,
  parameter int BYTES_W = 4
) (
  input  logic                   clk_data,
  input  logic                   rst_n,
  input  logic                   vd_i,
  input  sample_t                data_i,
  input  logic                   clear_i,
  input  logic                   flush_i,
  dec_pack_fifo_if.master        dout,
  output logic [AW:0]            level_o,
  output logic                   ovf_o
);
  logic [$clog2(BYTES_W)-1:0] byte_cnt;
  word_t pack, cur, rd;
  logic [AW-1:0] wr_ptr, rd_ptr, ra;
  logic [AW:0] rem;
  logic fl, push, pop, acc;
  assign pop = dout.valid && dout.ready;
  assign cur = vd_i ? lane_insert(pack, byte_cnt, data_i) : pack;
`ifdef DEC_PACK_FLUSH_EN
  assign fl = flush_i && (vd_i || byte_cnt != '0);
`else
  logic unused_flush;
  assign unused_flush = flush_i;
  assign fl = 1'b0;
`endif
  assign push = (vd_i && byte_cnt == 2'(BYTES_W - 1)) || fl;
  // a full FIFO still accepts when the head leaves at the same edge
  assign acc = push && (level_o != (AW+1)'(DEPTH) || pop);
  assign ra = rd_ptr + AW'(pop);
  // words already stored minus any leaving now; this-edge pushes show up one edge later
  assign rem = level_o - (AW+1)'(pop);
  dec_pack_fifo_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
    .clk_data(clk_data),
    .we(acc && !clear_i),
    .wa(wr_ptr),
    .wd(cur),
    .ra(ra),
    .rd(rd)
  );
  always_ff @(posedge clk_data or negedge rst_n) begin
    if (!rst_n) begin
      byte_cnt <= '0;
      pack <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level_o <= '0;
      ovf_o <= 1'b0;
      dout.valid <= 1'b0;
      dout.data <= '0;
    end else if (clear_i) begin
      byte_cnt <= '0;
      pack <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level_o <= '0;
      ovf_o <= 1'b0;
      dout.valid <= 1'b0;
    end else begin
      if (push) begin
        pack <= '0;
        byte_cnt <= '0;
      end else if (vd_i) begin
        pack <= cur;
        byte_cnt <= byte_cnt + 1'b1;
      end
      if (acc) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= ra;
      level_o <= level_o + (AW+1)'(acc) - (AW+1)'(pop);
      if (push && !acc) ovf_o <= 1'b1;
      dout.valid <= rem != '0;
      if (rem != '0) dout.data <= rd;
    end
  end
endmodule

// File: tb/tb_dec_pack_fifo.sv
// tb_dec_pack_fifo: directed stimulus against a queue-based model plus literal checks
module tb_dec_pack_fifo;
  import dec_pack_pkg::*;
  localparam int DEPTH = 16;
  logic clk_data = 0, rst_n = 0, vd = 0, clr = 0, fl = 0;
  logic [7:0] din = 0;
  logic [4:0] level;
  logic ovf;
  dec_pack_fifo_if bus();
  always #5 clk_data = ~clk_data;
  dec_pack_fifo #(.DEPTH(16), .AW(4), .BYTES_W(4)) dut (
    .clk_data(clk_data), .rst_n(rst_n), .vd_i(vd), .data_i(din), .clear_i(clr),
    .flush_i(fl), .dout(bus), .level_o(level), .ovf_o(ovf)
  );
  int pass = 0, total = 0;
  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    total++;
    if (a === e) pass++;
    else $display("FAIL %s: got %h expected %h", n, a, e);
  endtask
  logic [7:0] ln [4] = '{default: 0};
  int cnt = 0, n;
  logic [31:0] q [$];
  logic [31:0] md = 0, w;
  logic mv = 0, movf = 0;
  bit pp, pu, ff;
  always @(posedge clk_data or negedge rst_n) begin
    if (!rst_n || clr) begin
      q.delete();
      mv = 0;
      movf = 0;
      if (!rst_n) md = 0;
      ln = '{default: 0};
      cnt = 0;
    end else begin
      n = q.size();
      pp = mv && bus.ready;
      if (vd) ln[cnt] = din;
`ifdef DEC_PACK_FLUSH_EN
      ff = fl && (cnt != 0 || vd);
`else
      ff = 0;
`endif
      pu = (vd && cnt == 3) || ff;
      w = {ln[3], ln[2], ln[1], ln[0]};
      if (pu) begin
        ln = '{default: 0};
        cnt = 0;
      end else if (vd) cnt++;
      if (pp) void'(q.pop_front());
      if (pu) begin
        if (n < DEPTH || pp) q.push_back(w);
        else movf = 1;
      end
      mv = (n - int'(pp)) > 0;
      if (mv) md = q[0];
    end
  end
  always @(negedge clk_data) begin
    chk("valid", bus.valid, mv);
    chk("level", level, q.size());
    chk("ovf", ovf, movf);
    chk("data", bus.data, md);
  end
  logic [31:0] got [$];
  always @(negedge clk_data)
    if (rst_n && !clr && bus.valid && bus.ready) got.push_back(bus.data);
  task automatic step(bit v, logic [7:0] d, bit c = 0, bit f = 0);
    vd = v;
    din = d;
    clr = c;
    fl = f;
    @(posedge clk_data);
    #1;
  endtask
  initial begin
    bus.ready = 1;
    #2;
    chk("rst valid", bus.valid, 0);
    chk("rst level", level, 0);
    chk("rst ovf", ovf, 0);
    chk("rst data", bus.data, 0);
    #10 rst_n = 1;
    @(posedge clk_data);
    #1;
    step(1, 8'h11); step(1, 8'h22); step(1, 8'h33); step(1, 8'h44);
    chk("t1 level k", level, 1);
    chk("t1 valid k", bus.valid, 0);
    step(0, 0);
    chk("t1 valid k+1", bus.valid, 1);
    chk("t1 data", bus.data, 32'h44332211);
    chk("t1 level k+1", level, 1);
    step(0, 0);
    chk("t1 level pop", level, 0);
    chk("t1 valid pop", bus.valid, 0);
    chk("t1 data hold", bus.data, 32'h44332211);
    bus.ready = 0;
    got.delete();
    for (int i = 0; i < 68; i++) step(1, 8'(i));
    chk("t2 level full", level, 16);
    chk("t2 ovf", ovf, 1);
    bus.ready = 1;
    repeat (20) step(0, 0);
    chk("t2 drained", got.size(), 16);
    chk("t2 first", got[0], 32'h03020100);
    chk("t2 last", got[15], 32'h3F3E3D3C);
    chk("t2 ovf held", ovf, 1);
    step(0, 0, 1);
    chk("t2 ovf clr", ovf, 0);
    bus.ready = 0;
    for (int i = 0; i < 64; i++) step(1, 8'(i + 64));
    chk("t3 level full", level, 16);
    step(1, 8'hE0); step(1, 8'hE1); step(1, 8'hE2);
    got.delete();
    bus.ready = 1;
    step(1, 8'hE3);
    chk("t3 level", level, 16);
    chk("t3 ovf", ovf, 0);
    repeat (20) step(0, 0);
    chk("t3 count", got.size(), 17);
    chk("t3 first", got[0], 32'h43424140);
    chk("t3 last", got[16], 32'hE3E2E1E0);
    step(0, 0, 1);
    bus.ready = 0;
    for (int i = 1; i <= 6; i++) step(1, 8'(i));
    step(0, 0, 1);
    chk("t4 level", level, 0);
    chk("t4 valid", bus.valid, 0);
    chk("t4 ovf", ovf, 0);
    step(1, 8'hA0); step(1, 8'hA1); step(1, 8'hA2); step(1, 8'hA3);
    step(0, 0);
    chk("t4 valid", bus.valid, 1);
    chk("t4 data", bus.data, 32'hA3A2A1A0);
    step(1, 8'hC0); step(1, 8'hC1);
    vd = 0;
    #2 rst_n = 0;
    #1;
    chk("t5 valid async", bus.valid, 0);
    chk("t5 level async", level, 0);
    #3 rst_n = 1;
    @(posedge clk_data);
    #1;
    step(1, 8'hD0); step(1, 8'hD1); step(1, 8'hD2); step(1, 8'hD3);
    step(0, 0);
    chk("t5 valid", bus.valid, 1);
    chk("t5 data", bus.data, 32'hD3D2D1D0);
    step(0, 0, 1);
    step(1, 8'h7F); step(1, 8'h80);
    step(0, 0, 0, 1);
    step(0, 0); step(0, 0);
`ifdef DEC_PACK_FLUSH_EN
    chk("t6 valid", bus.valid, 1);
    chk("t6 data", bus.data, 32'h0000807F);
`else
    chk("t6 level", level, 0);
    chk("t6 valid", bus.valid, 0);
    step(1, 8'h01); step(1, 8'h02);
    step(0, 0);
    chk("t6 valid", bus.valid, 1);
    chk("t6 data", bus.data, 32'h0201807F);
`endif
    step(0, 0);
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
